xor_checksum_32: RTL and testbench

XOR_CHECKSUM_32 -- requirements
Module: xor_checksum_32

---
 rtl/xor_checksum_32_pkg.sv | 12 +
 rtl/xor_32_bits.sv | 12 +
 rtl/xor_checksum_32.sv | 100 ++++++++++
 tb/tb_xor_checksum_32.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/xor_checksum_32_pkg.sv
// Shared definitions for the XOR checksum block: datapath width and FSM state encoding.
package xor_checksum_32_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/xor_32_bits.sv
// Combinational 32-bit bitwise XOR used as the checksum fold datapath.
module xor_32_bits
    import xor_checksum_32_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] s
);

    assign s = a ^ b;

endmodule

// File: rtl/xor_checksum_32.sv
// XOR checksum engine: folds len words into a seeded 32-bit accumulator, pulses done with result.
module xor_checksum_32 #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned DATA_W = xor_checksum_32_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] seed,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [LEN_W-1:0]  count
);

    import xor_checksum_32_pkg::*;

    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_xor;
    logic [DATA_W-1:0] result_q, result_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  count_inc;

    xor_32_bits u_xor (
        .a (acc_q),
        .b (in_data),
        .s (acc_xor)
    );

    assign count_inc = count_q + LenOne;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        len_d    = len_q;
        count_d  = count_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = seed;
                    len_d   = len;
                    count_d = '0;
                    state_d = (len == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                // in_ready is implied by being in this state
                if (in_valid) begin
                    acc_d   = acc_xor;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Result is captured on entry to DONE so it is valid alongside the done pulse.
        if (state_d == StDone && state_q != StDone) begin
            result_d = acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            len_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            len_q    <= len_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign in_ready = (state_q == StAccum);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign count    = count_q;

endmodule

// File: tb/tb_xor_checksum_32.sv
// Directed bench for xor_checksum_32 with a job-level reference model checked every cycle.
module tb_xor_checksum_32;

    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      seed;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [31:0]      result;
    logic [LEN_W-1:0] count;

    int n_vec = 0;
    int n_err = 0;

    xor_checksum_32 #(
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .seed     (seed),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: a job is a seed, a word budget and the list of accepted words.
    bit          m_valid = 1'b0;
    bit          m_in_job;
    bit          m_done;
    int          m_len;
    logic [31:0] m_seed;
    logic [31:0] m_words[$];
    logic [31:0] m_result;

    function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] w[$]);
        logic [31:0] r = s;
        foreach (w[i]) r = r ^ w[i];
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n === 1'b0) begin
                m_valid  = 1'b1;
                m_in_job = 1'b0;
                m_done   = 1'b0;
                m_len    = 0;
                m_words.delete();
                m_result = '0;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (m_in_job) begin
                if (in_valid) begin
                    m_words.push_back(in_data);
                    if (m_words.size() == m_len) begin
                        m_result = fold(m_seed, m_words);
                        m_in_job = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end else if (start) begin
                m_seed = seed;
                m_len  = int'(len);
                m_words.delete();
                if (m_len == 0) begin
                    m_result = seed;
                    m_done   = 1'b1;
                end else begin
                    m_in_job = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("in_ready", 32'(in_ready), 32'(m_in_job));
                check("busy", 32'(busy), 32'(m_in_job | m_done));
                check("done", 32'(done), 32'(m_done));
                check("result", result, m_result);
                check("count", 32'(count), 32'(m_words.size()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] s, input int l);
        start = 1'b1;
        seed  = s;
        len   = LEN_W'(l);
        tick();
        start = 1'b0;
        seed  = 32'hDEAD_BEEF;
        len   = LEN_W'(7);
    endtask

    task automatic word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 32'h5A5A_5A5A;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        len      = LEN_W'(3);
        seed     = 32'h1234_5678;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_0000;
        tick();
        tick();
        check("rst_result", result, 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Two back-to-back words
        start_job(32'h0000_0000, 2);
        word(32'h0000_0001);
        word(32'hFFFF_FFFF);
        check("j1_done", 32'(done), 32'h1);
        check("j1_result", result, 32'hFFFF_FFFE);
        check("j1_count", 32'(count), 32'h2);
        tick();
        check("j1_hold_result", result, 32'hFFFF_FFFE);
        check("j1_hold_count", 32'(count), 32'h2);

        // Started in the IDLE cycle right after DONE; stall three cycles first
        start_job(32'hFFFF_FFFF, 1);
        tick();
        tick();
        tick();
        check("j2_stall_count", 32'(count), 32'h0);
        check("j2_stall_ready", 32'(in_ready), 32'h1);
        word(32'hFFFF_FFFF);
        check("j2_done", 32'(done), 32'h1);
        check("j2_result", result, 32'h0000_0000);
        tick();

        // Zero-length job
        start_job(32'h0000_0003, 0);
        check("j3_done", 32'(done), 32'h1);
        check("j3_result", result, 32'h0000_0003);
        check("j3_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("j3_done_clear", 32'(done), 32'h0);

        // Extra start mid-job is ignored
        start_job(32'h0000_0001, 3);
        start = 1'b1;
        seed  = 32'hAAAA_AAAA;
        len   = LEN_W'(1);
        word(32'h7FFF_FFFF);
        start = 1'b0;
        word(32'h0000_0003);
        check("j4_mid_busy", 32'(busy), 32'h1);
        word(32'h0000_0001);
        check("j4_done", 32'(done), 32'h1);
        check("j4_result", result, 32'h7FFF_FFFC);
        check("j4_count", 32'(count), 32'h3);
        tick();

        // Reset mid-job, with start and in_valid asserted alongside it
        start_job(32'h0000_0005, 4);
        word(32'h1111_1111);
        word(32'h2222_2222);
        rst_n    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        tick();
        check("j5_rst_done", 32'(done), 32'h0);
        check("j5_rst_busy", 32'(busy), 32'h0);
        check("j5_rst_count", 32'(count), 32'h0);
        check("j5_rst_result", result, 32'h0);
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        start_job(32'h0000_0000, 1);
        word(32'h0000_0002);
        check("j6_done", 32'(done), 32'h1);
        check("j6_result", result, 32'h0000_0002);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
